// File: rtl/bu2_ifft.sv
// Inverse-NTT radix-2 Cooley-Tukey butterfly: t = b*w mod q, a' = a+t, b' = a-t (mod q),
// with optional per-sample halving mod q. Fully pipelined, valid-tracked, globally stallable.
module bu2_ifft #(
  parameter int D_WIDTH = 64,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in1,
  input  logic [D_WIDTH-1:0] in2,
  input  logic [D_WIDTH-1:0] twiddle,
  input  logic [D_WIDTH-1:0] modulus,
  input  logic               inv_scale,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] ifft_a,
  output logic [D_WIDTH-1:0] ifft_b,
  output logic [D_WIDTH-1:0] twiddle_out,
  output logic [D_WIDTH-1:0] modulus_out,
  output logic               busy
);

  localparam int W  = D_WIDTH;
  localparam int PW = 2 * D_WIDTH;

  // Stage M: modular product, retimed across MUL_LAT register slots.
  logic [PW-1:0] prod;
  logic [W-1:0]  t_d;

  always_comb begin
    prod = PW'(in2) * PW'(twiddle);
    t_d  = '0;
    if (modulus != '0) t_d = W'(prod % PW'(modulus));
  end

  logic [W-1:0]       m_t_q [MUL_LAT];
  logic [W-1:0]       m_a_q [MUL_LAT];
  logic [W-1:0]       m_w_q [MUL_LAT];
  logic [W-1:0]       m_m_q [MUL_LAT];
  logic [MUL_LAT-1:0] m_inv_q;
  logic [MUL_LAT-1:0] m_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: pipeline arrays are cleared slot by slot so a mid-stream reset leaves no stale sample.
      for (int i = 0; i < MUL_LAT; i++) begin
        m_t_q[i] <= '0;
        m_a_q[i] <= '0;
        m_w_q[i] <= '0;
        m_m_q[i] <= '0;
      end
      m_inv_q <= '0;
      m_vld_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every slot shift from its predecessor's old value.
      m_t_q[0]   <= t_d;
      m_a_q[0]   <= in1;
      m_w_q[0]   <= twiddle;
      m_m_q[0]   <= modulus;
      m_inv_q[0] <= inv_scale;
      m_vld_q[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        m_t_q[i]   <= m_t_q[i-1];
        m_a_q[i]   <= m_a_q[i-1];
        m_w_q[i]   <= m_w_q[i-1];
        m_m_q[i]   <= m_m_q[i-1];
        m_inv_q[i] <= m_inv_q[i-1];
        m_vld_q[i] <= m_vld_q[i-1];
      end
    end
  end

  // Stage S: modular add/subtract in W+1 bits using the sample's own q.
  logic [W:0] a_ext, t_ext, q_ext, sum_raw, sum_d, diff_d;

  always_comb begin
    a_ext   = {1'b0, m_a_q[MUL_LAT-1]};
    t_ext   = {1'b0, m_t_q[MUL_LAT-1]};
    q_ext   = {1'b0, m_m_q[MUL_LAT-1]};
    sum_raw = a_ext + t_ext;
    sum_d   = (sum_raw >= q_ext) ? sum_raw - q_ext : sum_raw;
    diff_d  = (a_ext < t_ext) ? a_ext + q_ext - t_ext : a_ext - t_ext;
  end

  logic [W:0]   s_sum_q, s_diff_q;
  logic [W-1:0] s_w_q, s_m_q;
  logic         s_inv_q, s_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sum_q  <= '0;
      s_diff_q <= '0;
      s_w_q    <= '0;
      s_m_q    <= '0;
      s_inv_q  <= 1'b0;
      s_vld_q  <= 1'b0;
    end else if (en) begin
      s_sum_q  <= sum_d;
      s_diff_q <= diff_d;
      s_w_q    <= m_w_q[MUL_LAT-1];
      s_m_q    <= m_m_q[MUL_LAT-1];
      s_inv_q  <= m_inv_q[MUL_LAT-1];
      s_vld_q  <= m_vld_q[MUL_LAT-1];
    end
  end

  // x/2 mod q for odd q: an odd x becomes even after adding q, which cannot overflow W+1 bits.
  function automatic logic [W:0] halve(input logic [W:0] x, input logic [W:0] q, input logic inv);
    if (!inv)     return x;
    else if (x[0]) return (x + q) >> 1;
    else          return x >> 1;
  endfunction

  // Stage H: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      ifft_a      <= '0;
      ifft_b      <= '0;
      twiddle_out <= '0;
      modulus_out <= '0;
    end else if (en) begin
      out_valid   <= s_vld_q;
      ifft_a      <= W'(halve(s_sum_q, {1'b0, s_m_q}, s_inv_q));
      ifft_b      <= W'(halve(s_diff_q, {1'b0, s_m_q}, s_inv_q));
      twiddle_out <= s_w_q;
      modulus_out <= s_m_q;
    end
  end

  assign busy = (|m_vld_q) | s_vld_q | out_valid;

endmodule

// File: tb/tb_bu2_ifft.sv
// Self-checking bench for bu2_ifft: directed vector table, randomized streaming against a
// modular-arithmetic reference model, stall holding, and mid-stream asynchronous reset.
module tb_bu2_ifft;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, en, in_valid, inv_scale;
  logic [W-1:0] in1, in2, twiddle, modulus;
  logic         out_valid, busy;
  logic [W-1:0] ifft_a, ifft_b, twiddle_out, modulus_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bu2_ifft #(.D_WIDTH(W), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in1(in1), .in2(in2), .twiddle(twiddle), .modulus(modulus), .inv_scale(inv_scale),
    .out_valid(out_valid), .ifft_a(ifft_a), .ifft_b(ifft_b),
    .twiddle_out(twiddle_out), .modulus_out(modulus_out), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] a, b, w, q;
    logic         inv;
    logic [W-1:0] ea, eb;
  } vec_t;

  typedef struct {
    logic [W-1:0] ea, eb, w, q;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] w, input logic [W-1:0] q, input logic inv);
    in_valid  = v;
    in1       = a;
    in2       = b;
    twiddle   = w;
    modulus   = q;
    inv_scale = inv;
  endtask

  // Reference: plain modular arithmetic; halving is multiplication by the inverse of 2, (q+1)/2.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] w, input logic [W-1:0] q,
                                         input logic inv, input logic sel_b);
    logic [2*W-1:0] qq, t, x;
    qq = {{W{1'b0}}, q};
    t  = ({{W{1'b0}}, b} * {{W{1'b0}}, w}) % qq;
    x  = sel_b ? (({{W{1'b0}}, a} + qq - t) % qq) : (({{W{1'b0}}, a} + t) % qq);
    if (inv) x = (x * ((qq + 1) / 2)) % qq;
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One isolated sample: checks latency and all aligned outputs.
  task automatic run_single(input string tag, input vec_t v);
    int lat;
    drive(1'b1, v.a, v.b, v.w, v.q, v.inv);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      tick();
      in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    check({tag, "_latency"}, W'(lat), 64'd4);
    check({tag, "_a"}, ifft_a, v.ea);
    check({tag, "_b"}, ifft_b, v.eb);
    check({tag, "_tw"}, twiddle_out, v.w);
    check({tag, "_mod"}, modulus_out, v.q);
  endtask

  initial begin
    vecs[0] = '{a: 3,     b: 5,  w: 2,  q: 17,    inv: 1'b0, ea: 13, eb: 10};
    vecs[1] = '{a: 3,     b: 5,  w: 2,  q: 17,    inv: 1'b1, ea: 15, eb: 5};
    vecs[2] = '{a: 16,    b: 16, w: 16, q: 17,    inv: 1'b0, ea: 0,  eb: 15};
    vecs[3] = '{a: 16,    b: 16, w: 16, q: 17,    inv: 1'b1, ea: 0,  eb: 16};
    vecs[4] = '{a: 12288, b: 1,  w: 1,  q: 12289, inv: 1'b0, ea: 0,  eb: 12287};
    vecs[5] = '{a: 0,     b: 0,  w: 0,  q: 3,     inv: 1'b1, ea: 0,  eb: 0};

    rst_n = 1'b0;
    en    = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    #2;
    check("reset_out_valid", W'(out_valid), 64'd0);
    check("reset_ifft_a", ifft_a, 64'd0);
    check("reset_busy", W'(busy), 64'd0);
    #20 rst_n = 1'b1;
    en = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_single($sformatf("vec%0d", i), vecs[i]);

    // Randomized stream with bubbles, stalls, ignored stalled inputs and per-sample q changes.
    begin
      int sent, recv, budget;
      logic en_now;
      logic pv;
      logic [W-1:0] pa, pb, a, b, w, q;
      logic inv;
      exp_t e;
      sent = 0;
      recv = 0;
      budget = 0;
      while ((sent < 32 || sb.size() > 0) && budget < 2000) begin
        budget++;
        en_now = ($urandom_range(0, 9) >= 2);
        if (!en_now) begin
          drive(1'b1, rand64(), rand64(), rand64(), 64'd12289, 1'b1);
        end else if (sent < 32 && $urandom_range(0, 3) != 0) begin
          if (sent % 4 == 3) q = {3'b001, 61'(rand64())} | 64'd1;
          else               q = 64'd12289;
          a   = rand64() % q;
          b   = rand64() % q;
          w   = rand64() % q;
          inv = 1'($urandom_range(0, 1));
          drive(1'b1, a, b, w, q, inv);
          e.ea = model(a, b, w, q, inv, 1'b0);
          e.eb = model(a, b, w, q, inv, 1'b1);
          e.w  = w;
          e.q  = q;
          sb.push_back(e);
          sent++;
        end else begin
          drive(1'b0, rand64(), rand64(), rand64(), 64'd12289, 1'b0);
        end
        en = en_now;
        pv = out_valid;
        pa = ifft_a;
        pb = ifft_b;
        tick();
        if (!en_now) begin
          check("stall_hold_valid", W'(out_valid), W'(pv));
          check("stall_hold_a", ifft_a, pa);
          check("stall_hold_b", ifft_b, pb);
        end else if (out_valid) begin
          if (sb.size() == 0) begin
            check("stream_spurious_valid", W'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("stream_a", ifft_a, e.ea);
            check("stream_b", ifft_b, e.eb);
            check("stream_tw", twiddle_out, e.w);
            check("stream_mod", modulus_out, e.q);
            recv++;
          end
        end
      end
      check("stream_out_count", W'(recv), 64'd32);
      check("stream_in_count", W'(sent), 64'd32);
    end

    // Mid-stream asynchronous reset with three samples in flight.
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].q, vecs[i].inv);
      tick();
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    check("inflight_busy", W'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", W'(out_valid), 64'd0);
    check("rst_async_busy", W'(busy), 64'd0);
    check("rst_async_a", ifft_a, 64'd0);
    check("rst_async_b", ifft_b, 64'd0);
    check("rst_async_tw", twiddle_out, 64'd0);
    check("rst_async_mod", modulus_out, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (out_valid || busy) stale++;
      end
      check("post_reset_no_stale", W'(stale), 64'd0);
    end
    run_single("post_reset", vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bu2_ifft.md
Name: bu2_ifft

Overview:
- Inverse-NTT radix-2 Cooley-Tukey butterfly. Computes t = b·w mod q, then a' = a+t mod q and b' = a−t mod q.
- Optional per-sample divide-by-2 mod q folds the 1/N inverse scaling into each stage.
- Counterpart of the forward Gentleman-Sande butterfly: consumes forward-pipeline outputs and restores natural-domain coefficients.
- Fully pipelined with valid tracking and a global stall, so the INTT stage controller can stream one butterfly per cycle.

Parameters:
- D_WIDTH, 64, width of coefficients, twiddle and modulus.
- MUL_LAT, 2, cycles of the internal Barrett modular multiplier (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  pipeline advance; 0 freezes every stage, including valids
- in_valid  in  1  in1/in2/twiddle/modulus/inv_scale valid this cycle
- in1  in  D_WIDTH  butterfly input a, contract a<q
- in2  in  D_WIDTH  butterfly input b, contract b<q
- twiddle  in  D_WIDTH  inverse twiddle w, contract w<q
- modulus  in  D_WIDTH  q, odd, q≥3, q<2^(D_WIDTH−1)
- inv_scale  in  1  1: halve both results mod q
- out_valid  out  1  outputs below are a completed butterfly
- ifft_a  out  D_WIDTH  a' (optionally halved)
- ifft_b  out  D_WIDTH  b' (optionally halved)
- twiddle_out  out  D_WIDTH  twiddle aligned with outputs
- modulus_out  out  D_WIDTH  modulus aligned with outputs
- busy  out  1  any valid sample in flight (OR of all stage valids)

Behaviour:
- Reset: rst_n low asynchronously clears all data, valid and sideband registers to 0. All outputs read 0 during and after reset. Mid-operation reset discards in-flight samples; no partial result ever appears.
- Stage M (MUL_LAT cycles): modular multiply t = (in2·twiddle) mod q. in1, modulus, inv_scale and valid are delayed alongside it.
- Stage S (1 cycle): sum = a+t, minus q if ≥q. diff = a−t, plus q if a<t. Intermediates are D_WIDTH+1 bits and registered.
- Stage H (1 cycle, output register):
  - if inv_scale=1, x/2 mod q = x>>1 when x is even, else (x+q)>>1 computed in D_WIDTH+1 bits;
  - if inv_scale=0, x passes unchanged.
- Latency: exactly MUL_LAT+2 enabled cycles from in_valid sampled to out_valid, regardless of inv_scale. Default is 4.
- Throughput: one sample per enabled cycle. Back-to-back in_valid must produce back-to-back out_valid, order preserved.
- en=0: no register updates anywhere. Outputs hold their values, and out_valid holds its level. Inputs presented while en=0 are ignored.
- in_valid=0 with en=1: a bubble propagates. The data path may update, but out_valid=0 for that slot. Bench compares data only when out_valid=1.
- twiddle_out and modulus_out are the values sampled with the same sample.
- q may change per sample; every stage uses its own delayed q.
- Results are always in [0,q−1] given the input contract. Inputs outside the contract give unspecified data but correct valid timing.
- busy=0 iff every stage valid is 0.

Test Plan:
- Basic, inv_scale=0: q=17, a=3, b=5, w=2 -> out_valid exactly 4 cycles later; ifft_a=13, ifft_b=10, twiddle_out=2, modulus_out=17.
- Basic, inv_scale=1: same vector -> ifft_a=15, ifft_b=5.
- Wrap-around: q=17, a=16, b=16, w=16 -> inv_scale=0 gives 0/15; inv_scale=1 gives 0/16.
- Large q=12289, a=12288, b=1, w=1 -> 0/12287.
- Streaming: 32 random back-to-back vectors (q=12289) with random bubbles and random en=0 gaps -> outputs match the golden model in order; out_valid count equals in_valid count; outputs held during stalls.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> all outputs and busy are 0 immediately (asynchronous); after release, no stale out_valid appears. A fresh sample completes in 4 cycles.
